// File: rtl/rv32i_types.sv
// Shared RV32I branch-unit types: funct3 encodings, iterative comparator state,
// and the mapping from eq/lt flags to a branch decision.
package rv32i_types;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } branch_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } iter_cmp_state_t;

  // Reserved funct3 codes (010, 011) never take the branch.
  function automatic logic br_map(input branch_funct3_t op, input logic eq, input logic lt);
    logic br;
    br = 1'b0;
    case (op)
      BEQ:         br = eq;
      BNE:         br = !eq;
      BLT, BLTU:   br = lt;
      BGE, BGEU:   br = !lt;
      default:     br = 1'b0;
    endcase
    return br;
  endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational compare of one operand chunk; signed_en_i treats the chunk as
// two's complement (used only for the most-significant chunk of signed ops).
module chunk_cmp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             signed_en_i,
  output logic             eq_o,
  output logic             lt_o
);

  always_comb begin
    eq_o = (a_i == b_i);
    if (signed_en_i) lt_o = ($signed(a_i) < $signed(b_i));
    else             lt_o = (a_i < b_i);
  end

endmodule

// File: rtl/iter_cmp.sv
// Multi-cycle RV32I branch comparator: scans operands CHUNK bits per cycle from
// the top chunk down, with valid/ready request and response handshakes.
//
//   state | meaning
//   IDLE  | ready for a request; operands latched on accept
//   SCAN  | comparing chunk idx; first differing chunk fixes lt
//   DONE  | br_en valid and held until resp_ready
module iter_cmp
  import rv32i_types::*;
#(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           abort,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  branch_funct3_t cmpop,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic           br_en
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

  iter_cmp_state_t state_q, state_d;
  logic [NCHUNK-1:0][CHUNK-1:0] a_q, a_d, b_q, b_d;
  branch_funct3_t op_q, op_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic eq_q, eq_d, lt_q, lt_d;
  logic br_en_q, br_en_d;

  logic c_eq, c_lt, c_signed, diff, last;

  assign c_signed = (idx_q == IDX_TOP) && ((op_q == BLT) || (op_q == BGE));

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .a_i        (a_q[idx_q]),
    .b_i        (b_q[idx_q]),
    .signed_en_i(c_signed),
    .eq_o       (c_eq),
    .lt_o       (c_lt)
  );

  assign req_ready  = (state_q == IDLE) && !rst && !abort;
  assign resp_valid = (state_q == DONE);
  assign br_en      = br_en_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    idx_d   = idx_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    br_en_d = br_en_q;
    diff    = !c_eq;
    last    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && !abort) begin
          a_d     = a;
          b_d     = b;
          op_d    = cmpop;
          idx_d   = IDX_TOP;
          eq_d    = 1'b1;
          lt_d    = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          // Only the first difference decides lt; lower chunks are less significant.
          if (eq_q && diff) begin
            eq_d = 1'b0;
            lt_d = c_lt;
          end
          last = (idx_q == '0) || (EARLY_EXIT && diff);
          if (last) begin
            state_d = DONE;
            br_en_d = br_map(op_q, eq_d, lt_d);
          end else begin
            idx_d = idx_q - IDXW'(1);
          end
        end
      end
      DONE: begin
        if (abort || resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= BEQ;
      idx_q   <= IDX_TOP;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      br_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      br_en_q <= br_en_d;
    end
  end

endmodule

// File: tb/tb_iter_cmp.sv
// Directed bench for iter_cmp: one early-exit and one fixed-latency instance
// sharing operand inputs, checked against hand-computed results and latencies.
module tb_iter_cmp;
  import rv32i_types::*;

  logic clk = 1'b0;
  logic rst, abort;
  logic [31:0] a, b;
  branch_funct3_t cmpop;
  logic rv0, rr0, vv0, ry0, br0;
  logic rv1, rr1, vv1, ry1, br1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  iter_cmp #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1'b1)) dut0 (
    .clk(clk), .rst(rst), .abort(abort),
    .req_valid(rv0), .req_ready(rr0), .a(a), .b(b), .cmpop(cmpop),
    .resp_valid(vv0), .resp_ready(ry0), .br_en(br0)
  );

  iter_cmp #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1'b0)) dut1 (
    .clk(clk), .rst(rst), .abort(abort),
    .req_valid(rv1), .req_ready(rr1), .a(a), .b(b), .cmpop(cmpop),
    .resp_valid(vv1), .resp_ready(ry1), .br_en(br1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Issue one op, measure edges to resp_valid, check result and the return to IDLE.
  task automatic do_op(input int sel, input branch_funct3_t op, input logic [31:0] av,
                       input logic [31:0] bv, input logic exp_br, input int exp_k,
                       input string tag);
    int k;
    @(negedge clk);
    a = av; b = bv; cmpop = op;
    if (sel == 1) rv1 = 1'b1; else rv0 = 1'b1;
    check({tag, ":req_ready"}, (sel == 1) ? rr1 : rr0, 1);
    @(posedge clk); #1;
    rv0 = 1'b0; rv1 = 1'b0;
    a = ~av; b = av ^ 32'h5A5A_5A5A; cmpop = branch_funct3_t'(3'b011);
    k = 0;
    while (!((sel == 1) ? vv1 : vv0) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, ":latency"}, k, exp_k);
    check({tag, ":br_en"}, (sel == 1) ? br1 : br0, exp_br);
    @(posedge clk); #1;
    check({tag, ":idle_again"}, (sel == 1) ? {vv1, rr1} : {vv0, rr0}, 2'b01);
  endtask

  initial begin
    int k;
    rst = 1'b1; abort = 1'b0; rv0 = 1'b0; rv1 = 1'b0; ry0 = 1'b1; ry1 = 1'b1;
    a = '0; b = '0; cmpop = BEQ;
    repeat (3) @(posedge clk);
    #1;
    check("reset:resp_valid", vv0, 0);
    check("reset:br_en", br0, 0);
    check("reset:req_ready", rr0, 0);
    @(negedge clk); rst = 1'b0; #1;
    check("post_reset:req_ready", rr0, 1);

    do_op(0, BLT,  32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1, "blt_neg");
    do_op(0, BLTU, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1, "bltu_big");
    do_op(0, BEQ,  32'h1234_5678, 32'h1234_5678, 1'b1, 4, "beq_eq");
    do_op(0, BNE,  32'h1234_5678, 32'h1234_5678, 1'b0, 4, "bne_eq");
    do_op(0, BGE,  32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1, "bge_min");
    do_op(0, BGEU, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1, "bgeu_min");
    do_op(0, BLTU, 32'h0000_0004, 32'h0000_0005, 1'b1, 4, "bltu_low");
    do_op(0, branch_funct3_t'(3'b010), 32'h0000_0001, 32'h0000_0002, 1'b0, 4, "undef_op");
    do_op(1, BLT,  32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 4, "fixed_blt");
    do_op(1, BLTU, 32'h01FF_0000, 32'h0200_0000, 1'b1, 4, "fixed_first_diff");

    // Backpressure: hold resp_ready low for 3 cycles in DONE.
    ry0 = 1'b0;
    @(negedge clk);
    a = 32'hCAFE_F00D; b = 32'hCAFE_F00D; cmpop = BEQ; rv0 = 1'b1;
    @(posedge clk); #1; rv0 = 1'b0; a = '0;
    k = 0;
    while (!vv0 && k < 20) begin @(posedge clk); #1; k++; end
    check("hold:latency", k, 4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold:stable", {vv0, br0, rr0}, 3'b110);
    end
    @(negedge clk); ry0 = 1'b1;
    @(posedge clk); #1;
    check("hold:release", {vv0, rr0}, 2'b01);
    do_op(0, BNE, 32'h0000_0001, 32'h0000_0000, 1'b1, 4, "after_hold");

    // Abort during SCAN with idx = 2 (one edge after accept).
    @(negedge clk);
    a = 32'h0000_0004; b = 32'h0000_0005; cmpop = BLTU; rv0 = 1'b1;
    @(posedge clk); #1; rv0 = 1'b0;
    @(posedge clk); #1; abort = 1'b1;
    check("abort:idle_blocked", rr0, 0);
    @(posedge clk); #1; abort = 1'b0; #1;
    check("abort:back_idle", {vv0, rr0}, 2'b01);
    k = 0;
    repeat (5) begin @(posedge clk); #1; if (vv0) k++; end
    check("abort:no_resp", k, 0);

    // Reset while holding a result in DONE.
    ry0 = 1'b0;
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'h0000_0001; cmpop = BLT; rv0 = 1'b1;
    @(posedge clk); #1; rv0 = 1'b0;
    @(posedge clk); #1;
    check("rst_done:pre", {vv0, br0}, 2'b11);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rst_done:cleared", {vv0, br0}, 2'b00);
    check("rst_done:ready_low", rr0, 0);
    @(negedge clk); rst = 1'b0; ry0 = 1'b1; #1;
    check("rst_done:ready_back", rr0, 1);
    do_op(0, BGEU, 32'h0000_0005, 32'h0000_0005, 1'b1, 4, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
